apu_cmd_sequencer: RTL and testbench

APU_CMD_SEQUENCER -- requirements
Module: apu_cmd_sequencer

---
 rtl/apu_cmd_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_apu_cmd_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_cmd_sequencer.sv
// APU command sequencer: 16-byte host FIFO feeding a sound chip
// write bus, with command framing, ACK handshaking and timeout.
module apu_cmd_sequencer #(
  parameter int WR_PULSE    = 4,
  parameter int GAP         = 8,
  parameter int ACK_TIMEOUT = 4095
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       WR_STB,
  input  logic [7:0] WR_DATA,
  input  logic       ERR_CLR,
  input  logic       ACK,
  output logic [7:0] DB_O,
  output logic       WRB,
  output logic       CSB,
  output logic       FULL,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_BLANK,
    S_WAIT_ACK,
    S_GAP
  } state_t;

  typedef enum logic [1:0] {
    M_NONE,
    M_COUNT,
    M_PCM
  } mode_t;

  localparam logic [11:0] PULSE_LAST = 12'(WR_PULSE - 1);
  localparam logic [11:0] GAP_LAST   =
    12'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [11:0] TMO_LAST   = 12'(ACK_TIMEOUT - 1);

  logic [7:0]  mem [16];
  logic [3:0]  wptr;
  logic [3:0]  rptr;
  logic [4:0]  count;
  logic        empty;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  state_t      state;
  state_t      state_n;
  logic [11:0] cnt;
  logic [11:0] cnt_n;
  logic        tmo;

  mode_t       mode;
  mode_t       mode_n;
  logic [3:0]  rem;
  logic [3:0]  rem_n;
  logic        last_fe;
  logic        last_fe_n;
  logic        fin_n;
  logic        cur_final;

  assign empty = (count == 5'd0);
  assign FULL  = (count == 5'd16);
  assign BUSY  = !empty || (state != S_IDLE);
  assign push  = WR_STB && !FULL;
  assign head  = mem[rptr];

  // FIFO storage; contents only matter between push and pop
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr] <= WR_DATA;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      wptr  <= 4'd0;
      rptr  <= 4'd0;
      count <= 5'd0;
    end else begin
      if (push) begin
        wptr <= wptr + 4'd1;
      end
      if (pop) begin
        rptr <= rptr + 4'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Classify the byte at the FIFO head against the open command
  always_comb begin
    mode_n    = mode;
    rem_n     = rem;
    last_fe_n = last_fe;
    fin_n     = 1'b0;
    unique case (mode)
      M_NONE: begin
        case (head)
          8'h01: begin
            mode_n = M_COUNT;
            rem_n  = 4'd9;
          end
          8'h02: begin
            mode_n = M_COUNT;
            rem_n  = 4'd3;
          end
          8'h1F: begin
            mode_n    = M_PCM;
            last_fe_n = 1'b0;
          end
          default: fin_n = 1'b1;
        endcase
      end
      M_COUNT: begin
        rem_n = rem - 4'd1;
        if (rem == 4'd1) begin
          fin_n  = 1'b1;
          mode_n = M_NONE;
        end
      end
      M_PCM: begin
        last_fe_n = (head == 8'hFE);
        if (last_fe && (head == 8'h00)) begin
          fin_n     = 1'b1;
          mode_n    = M_NONE;
          last_fe_n = 1'b0;
        end
      end
      default: begin
        mode_n    = M_NONE;
        rem_n     = 4'd0;
        last_fe_n = 1'b0;
      end
    endcase
  end

  // Framing state advances on each pop; a timeout aborts it
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      mode      <= M_NONE;
      rem       <= 4'd0;
      last_fe   <= 1'b0;
      cur_final <= 1'b0;
    end else if (tmo) begin
      mode      <= M_NONE;
      rem       <= 4'd0;
      last_fe   <= 1'b0;
      cur_final <= 1'b0;
    end else if (pop) begin
      mode      <= mode_n;
      rem       <= rem_n;
      last_fe   <= last_fe_n;
      cur_final <= fin_n;
    end
  end

  // Next-state logic; cnt is the per-state phase counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_SETUP;
          cnt_n   = 12'd0;
        end
      end
      S_SETUP: begin
        state_n = S_STROBE;
        cnt_n   = 12'd0;
      end
      S_STROBE: begin
        if (cnt == PULSE_LAST) begin
          cnt_n = 12'd0;
          if (!cur_final) begin
            state_n = S_BLANK;
          end else if (GAP == 0) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_GAP;
          end
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = S_IDLE;
          cnt_n   = 12'd0;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      S_BLANK: begin
        if (cnt == 12'd1) begin
          state_n = S_WAIT_ACK;
          cnt_n   = 12'd0;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      S_WAIT_ACK: begin
        if (ACK) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_SETUP;
            cnt_n   = 12'd0;
          end
        end else if (cnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = S_IDLE;
          cnt_n   = 12'd0;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 12'd0;
      end
    endcase
  end

  // State register and phase counter
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state <= S_IDLE;
      cnt   <= 12'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Registered bus outputs: strobes low only while in STROBE
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      DB_O <= 8'h00;
      WRB  <= 1'b1;
      CSB  <= 1'b1;
    end else begin
      if (pop) begin
        DB_O <= head;
      end
      WRB <= (state_n != S_STROBE);
      CSB <= (state_n != S_STROBE);
    end
  end

  // Sticky timeout flag; a timeout beats a same-cycle clear
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ERR <= 1'b0;
    end else if (tmo) begin
      ERR <= 1'b1;
    end else if (ERR_CLR) begin
      ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apu_cmd_sequencer.sv
// Randomized bench for apu_cmd_sequencer with a command-level
// reference model of bus writes, timing and FIFO behaviour.
module tb_apu_cmd_sequencer;

  localparam int WR_PULSE    = 4;
  localparam int GAP         = 8;
  localparam int ACK_TIMEOUT = 4095;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_stb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       err_clr = 1'b0;
  logic       ack;
  logic [7:0] db_o;
  logic       wrb;
  logic       csb;
  logic       full;
  logic       busy;
  logic       err;

  logic ack_r = 1'b0;
  logic ack_force = 1'b0;
  assign ack = ack_r | ack_force;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  int last_fall_cyc = 0;
  logic ack_en = 1'b0;
  int ack_dly = -1;

  logic [7:0] exp_q[$];
  int         pcyc_q[$];
  logic [7:0] pend_q[$];

  int mode = 0;
  int rem = 0;
  logic last_fe = 1'b0;

  apu_cmd_sequencer #(
    .WR_PULSE(WR_PULSE),
    .GAP(GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CLK(clk),
    .RES(rst),
    .WR_STB(wr_stb),
    .WR_DATA(wr_data),
    .ERR_CLR(err_clr),
    .ACK(ack),
    .DB_O(db_o),
    .WRB(wrb),
    .CSB(csb),
    .FULL(full),
    .BUSY(busy),
    .ERR(err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Command framing rules: opcode sets length, PCM ends on FE,00
  task automatic frame(input logic [7:0] b, output logic fin);
    fin = 1'b0;
    if (mode == 0) begin
      if (b == 8'h01) begin
        mode = 1;
        rem = 9;
      end else if (b == 8'h02) begin
        mode = 1;
        rem = 3;
      end else if (b == 8'h1F) begin
        mode = 2;
        last_fe = 1'b0;
      end else begin
        fin = 1'b1;
      end
    end else if (mode == 1) begin
      rem = rem - 1;
      if (rem == 0) begin
        fin = 1'b1;
        mode = 0;
      end
    end else begin
      if (last_fe && b == 8'h00) begin
        fin = 1'b1;
        mode = 0;
      end
      last_fe = (b == 8'hFE);
    end
  endtask

  task automatic model_clear();
    mode = 0;
    rem = 0;
    last_fe = 1'b0;
  endtask

  // Watches the bus, scores each write and answers with ACK
  task automatic monitor();
    logic pw;
    logic fin;
    logic [7:0] db;
    logic [7:0] e;
    int lo, hi, ex, dcnt, rise_cyc, pc, d;
    pw = 1'b1;
    fin = 1'b0;
    db = 8'h00;
    lo = 0;
    hi = 0;
    ex = -1;
    dcnt = -1;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pw = 1'b1;
        ex = -1;
        dcnt = -1;
        lo = 0;
        hi = 0;
        ack_r = 1'b0;
        continue;
      end
      check("cs_eq_wr", 32'(csb), 32'(wrb));
      if (pw && !wrb) begin
        ack_r = 1'b0;
        dcnt = -1;
        db = db_o;
        lo = 1;
        pulses++;
        last_fall_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("wr_extra", 32'(db_o), 32'h100);
        end else begin
          e = exp_q.pop_front();
          pc = pcyc_q.pop_front();
          check("wr_data", 32'(db_o), 32'(e));
          if (ex >= 0 && pc <= rise_cyc)
            check("wr_gap", hi, ex);
          frame(e, fin);
        end
      end else if (!pw && !wrb) begin
        lo++;
        check("db_stable", 32'(db_o), 32'(db));
      end else if (!pw && wrb) begin
        check("wr_width", lo, WR_PULSE);
        check("db_hold", 32'(db_o), 32'(db));
        hi = 1;
        rise_cyc = cyc;
        if (fin) begin
          ex = GAP + 2;
        end else if (ack_en) begin
          d = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 10));
          ex = ((d > 2) ? d : 2) + 2;
          dcnt = d;
        end else begin
          ex = -1;
        end
      end else begin
        hi++;
      end
      if (dcnt == 0) begin
        ack_r = 1'b1;
        dcnt = -1;
      end else if (dcnt > 0) begin
        dcnt--;
      end
      pw = wrb;
    end
  endtask

  // Pushes pend_q one byte per cycle; model drops pushes when full
  task automatic burst();
    foreach (pend_q[i]) begin
      wr_stb = 1'b1;
      wr_data = pend_q[i];
      if (exp_q.size() < 16) begin
        exp_q.push_back(pend_q[i]);
        pcyc_q.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    wr_stb = 1'b0;
    pend_q.delete();
  endtask

  task automatic wait_lvl(input logic v, input string tag);
    int n;
    n = 0;
    while (wrb !== v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (wrb !== v) check(tag, 32'(wrb), 32'(v));
  endtask

  task automatic wait_rise(input string tag);
    wait_lvl(1'b0, tag);
    wait_lvl(1'b1, tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    check("q_empty", exp_q.size(), 0);
    check("full_idle", 32'(full), 32'd0);
  endtask

  task automatic gen_cmds();
    logic [7:0] tmp[$];
    logic [7:0] b;
    int k, len, tries;
    tries = 0;
    while (pend_q.size() < 12 && tries < 50) begin
      tries++;
      tmp.delete();
      k = int'($urandom_range(0, 3));
      if (k == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h01 || b == 8'h02 || b == 8'h1F) b = 8'h00;
        tmp.push_back(b);
      end else if (k == 1) begin
        tmp.push_back(8'h01);
        for (int i = 0; i < 9; i++)
          tmp.push_back(8'($urandom_range(0, 255)));
      end else if (k == 2) begin
        tmp.push_back(8'h02);
        for (int i = 0; i < 3; i++)
          tmp.push_back(8'($urandom_range(0, 255)));
      end else begin
        tmp.push_back(8'h1F);
        len = int'($urandom_range(0, 4));
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            tmp.push_back(8'hFE);
            tmp.push_back(8'h55);
          end else begin
            tmp.push_back(8'($urandom_range(0, 253)));
          end
        end
        tmp.push_back(8'hFE);
        tmp.push_back(8'h00);
      end
      if (pend_q.size() + tmp.size() <= 16)
        foreach (tmp[i]) pend_q.push_back(tmp[i]);
    end
  endtask

  initial begin
    int n, p0, t_push, nb;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_wrb", 32'(wrb), 32'd1);
    check("rst_csb", 32'(csb), 32'd1);
    check("rst_db", 32'(db_o), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);

    rst = 1'b0;
    ack_en = 1'b1;
    ack_dly = -1;
    t_push = cyc + 1;
    p0 = pulses;
    pend_q.push_back(8'h00);
    burst();
    check("busy_push", 32'(busy), 32'd1);
    wait_rise("single_rise");
    check("first_pop", last_fall_cyc - t_push, 2);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("gap_busy", n, GAP);
    check("single_n", pulses - p0, 1);

    ack_dly = 10;
    p0 = pulses;
    pend_q = '{8'h02, 8'h10, 8'h20, 8'h30};
    burst();
    wait_idle("cnt_idle");
    check("cnt_n", pulses - p0, 4);

    ack_dly = -1;
    p0 = pulses;
    pend_q = '{8'h1F, 8'h80, 8'hFE, 8'h00, 8'h00};
    burst();
    wait_idle("pcm_idle");
    check("pcm_n", pulses - p0, 5);

    ack_en = 1'b0;
    pend_q.push_back(8'h01);
    burst();
    wait_rise("tmo_rise");
    n = 0;
    while (!err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, ACK_TIMEOUT + 2);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);
    model_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);

    err_clr = 1'b1;
    pend_q.push_back(8'h02);
    burst();
    wait_rise("prio_rise");
    n = 0;
    while (!err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    err_clr = 1'b0;
    check("prio_cycles", n, ACK_TIMEOUT + 2);
    @(negedge clk);
    check("prio_err", 32'(err), 32'd1);
    model_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("prio_clr", 32'(err), 32'd0);

    p0 = pulses;
    pend_q.push_back(8'h01);
    burst();
    wait_rise("full_rise");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++)
      pend_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 7; i++)
      pend_q.push_back(8'(8'h40 + i));
    pend_q.push_back(8'hEE);
    burst();
    check("full_set", 32'(full), 32'd1);
    check("full_busy", 32'(busy), 32'd1);
    check("full_model", exp_q.size(), 16);
    ack_en = 1'b1;
    ack_force = 1'b1;
    wait_lvl(1'b0, "full_resume");
    ack_force = 1'b0;
    wait_idle("full_idle");
    check("full_n", pulses - p0, 17);

    for (int r = 0; r < 12; r++) begin
      ack_dly = -1;
      gen_cmds();
      nb = pend_q.size();
      p0 = pulses;
      burst();
      wait_idle("rnd_idle");
      check("rnd_n", pulses - p0, nb);
    end

    ack_dly = 0;
    pend_q = '{8'h01, 8'h33};
    burst();
    wait_lvl(1'b0, "rst_strobe");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rs_wrb", 32'(wrb), 32'd1);
    check("rs_csb", 32'(csb), 32'd1);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_full", 32'(full), 32'd0);
    check("rs_db", 32'(db_o), 32'd0);
    exp_q.delete();
    pcyc_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    pend_q = '{8'h00, 8'h77};
    burst();
    wait_idle("rs_idle");
    check("rs_n", pulses - p0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
